// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I decode constants and the registered ID/EX control bundle type.
// Imported by rv_ctrl_decode and rv_decode_stage.
package rv_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRX     = 3'b101;

   // Immediate is kept at 32 bits; the stage sign-extends it to XLEN.
   typedef struct packed {
      logic [3:0]  aluOp;
      logic        aluSrcImm;
      logic        isBranch;
      logic        isJal;
      logic        isJalr;
      logic        isAuipc;
      logic        isLui;
      logic        isLoad;
      logic        isStore;
      logic        isMuldiv;
      logic        rwe;
      logic        illegal;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  func3;
      logic [31:0] imm;
   } ctrl_bundle_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32I control decode and immediate generation.
// Optional: define RV_MEXT_EN to accept M-extension OP encodings.
module rv_ctrl_decode
   import rv_ctrl_pkg::*;
(
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl
);

   logic [6:0]  opcode;
   logic [6:0]  func7;
   logic [2:0]  func3;
   logic [31:0] immI;
   logic [31:0] immS;
   logic [31:0] immB;
   logic [31:0] immU;
   logic [31:0] immJ;
   logic        bad;

   assign opcode = instr[6:0];
   assign func3  = instr[14:12];
   assign func7  = instr[31:25];

   assign immI = {{20{instr[31]}}, instr[31:20]};
   assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign immU = {instr[31:12], 12'b0};
   assign immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      ctrl       = '0;
      bad        = 1'b0;
      ctrl.rd    = instr[11:7];
      ctrl.rs1   = instr[19:15];
      ctrl.rs2   = instr[24:20];
      ctrl.func3 = func3;
      ctrl.aluOp = {1'b0, func3};
      case (opcode)
         OPC_LOAD: begin
            ctrl.isLoad = 1'b1;
            ctrl.aluOp  = '0;
            ctrl.imm    = immI;
         end
         OPC_STORE: begin
            ctrl.isStore = 1'b1;
            ctrl.aluOp   = '0;
            ctrl.imm     = immS;
         end
         OPC_OP: begin
            ctrl.aluOp = {func7[5], func3};
            if (func7 == F7_MULDIV) begin
`ifdef RV_MEXT_EN
               ctrl.isMuldiv = 1'b1;
               ctrl.aluOp    = {1'b0, func3};
`else
               bad = 1'b1;
`endif
            end else if (func7 != F7_BASE && func7 != F7_ALT) begin
               bad = 1'b1;
            end
         end
         OPC_OPIMM: begin
            ctrl.aluSrcImm = 1'b1;
            ctrl.imm       = immI;
            // Shift-immediates reuse the upper immediate bits as func7.
            if (func3 == F3_SLL) begin
               ctrl.aluOp = {func7[5], func3};
               bad        = (func7 != F7_BASE);
            end else if (func3 == F3_SRX) begin
               ctrl.aluOp = {func7[5], func3};
               bad        = (func7 != F7_BASE) && (func7 != F7_ALT);
            end
         end
         OPC_BRANCH: begin
            ctrl.isBranch = 1'b1;
            ctrl.imm      = immB;
         end
         OPC_JAL: begin
            ctrl.isJal = 1'b1;
            ctrl.imm   = immJ;
         end
         OPC_JALR: begin
            ctrl.isJalr = 1'b1;
            ctrl.imm    = immI;
         end
         OPC_AUIPC: begin
            ctrl.isAuipc = 1'b1;
            ctrl.imm     = immU;
         end
         OPC_LUI: begin
            ctrl.isLui = 1'b1;
            ctrl.imm   = immU;
         end
         default: bad = 1'b1;
      endcase

      // Illegal words keep their register fields but carry no operation.
      if (bad) begin
         ctrl.illegal   = 1'b1;
         ctrl.aluOp     = '0;
         ctrl.aluSrcImm = 1'b0;
         ctrl.isMuldiv  = 1'b0;
         ctrl.imm       = '0;
      end
      ctrl.rwe = !ctrl.isBranch && !ctrl.isStore && !ctrl.illegal && (ctrl.rd != '0);
   end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered ID/EX decode stage: valid/ready handshake, flush, load-use bubble
// and saturating stall counter. Optional: RV_MEXT_EN (see rv_ctrl_decode).
module rv_decode_stage
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3:0]             out_alu_op,
   output logic                   out_alu_src_imm,
   output logic                   out_is_branch,
   output logic                   out_is_jal,
   output logic                   out_is_jalr,
   output logic                   out_is_auipc,
   output logic                   out_is_lui,
   output logic                   out_is_load,
   output logic                   out_is_store,
   output logic                   out_is_muldiv,
   output logic                   out_rwe,
   output logic                   out_illegal,
   output logic [REG_AW-1:0]      out_rd,
   output logic [REG_AW-1:0]      out_rs1,
   output logic [REG_AW-1:0]      out_rs2,
   output logic [2:0]             out_func3,
   output logic [XLEN-1:0]        out_imm,
   output logic [STALL_CNT_W-1:0] stall_count
);

   ctrl_bundle_t           decCtrl;
   ctrl_bundle_t           bundleQ;
   logic                   validQ;
   logic [STALL_CNT_W-1:0] stallQ;
   logic                   usesRs1;
   logic                   usesRs2;
   logic                   hazard;
   logic                   accept;

   rv_ctrl_decode uDecode (
      .instr (in_instr),
      .ctrl  (decCtrl)
   );

   // Load-use check of the incoming word against the load held in ID/EX.
   always_comb begin
      usesRs1 = !(decCtrl.isLui || decCtrl.isAuipc || decCtrl.isJal);
      usesRs2 = decCtrl.isStore || decCtrl.isBranch ||
                (!decCtrl.illegal && (in_instr[6:0] == OPC_OP));
      hazard  = in_valid && validQ && bundleQ.isLoad && (bundleQ.rd != '0) &&
                ((usesRs1 && (decCtrl.rs1 == bundleQ.rd)) ||
                 (usesRs2 && (decCtrl.rs2 == bundleQ.rd)));
   end

   assign in_ready = (!validQ || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         validQ  <= 1'b0;
         bundleQ <= '0;
      end else if (flush) begin
         validQ <= 1'b0;
      end else if (accept) begin
         validQ  <= 1'b1;
         bundleQ <= decCtrl;
      end else if (out_ready) begin
         validQ <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallQ <= '0;
      end else if (hazard && out_ready && !flush && (stallQ != '1)) begin
         stallQ <= stallQ + STALL_CNT_W'(1);
      end
   end

   generate
      if (XLEN > 32) begin : gImmWide
         assign out_imm = {{(XLEN-32){bundleQ.imm[31]}}, bundleQ.imm};
      end else begin : gImmNarrow
         assign out_imm = bundleQ.imm[XLEN-1:0];
      end
   endgenerate

   assign out_valid       = validQ;
   assign stall_count     = stallQ;
   assign out_alu_op      = bundleQ.aluOp;
   assign out_alu_src_imm = bundleQ.aluSrcImm;
   assign out_is_branch   = bundleQ.isBranch;
   assign out_is_jal      = bundleQ.isJal;
   assign out_is_jalr     = bundleQ.isJalr;
   assign out_is_auipc    = bundleQ.isAuipc;
   assign out_is_lui      = bundleQ.isLui;
   assign out_is_load     = bundleQ.isLoad;
   assign out_is_store    = bundleQ.isStore;
   assign out_is_muldiv   = bundleQ.isMuldiv;
   assign out_rwe         = bundleQ.rwe;
   assign out_illegal     = bundleQ.illegal;
   assign out_rd          = REG_AW'(bundleQ.rd);
   assign out_rs1         = REG_AW'(bundleQ.rs1);
   assign out_rs2         = REG_AW'(bundleQ.rs2);
   assign out_func3       = bundleQ.func3;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed cases plus randomized
// traffic compared against a behavioural decode/handshake reference model.
module tb_rv_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alu_op;
   logic        out_alu_src_imm;
   logic        out_is_branch;
   logic        out_is_jal;
   logic        out_is_jalr;
   logic        out_is_auipc;
   logic        out_is_lui;
   logic        out_is_load;
   logic        out_is_store;
   logic        out_is_muldiv;
   logic        out_rwe;
   logic        out_illegal;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [2:0]  out_func3;
   logic [31:0] out_imm;
   logic [15:0] stall_count;

   always #5 clk = ~clk;

   rv_decode_stage #(
      .XLEN        (32),
      .REG_AW      (5),
      .STALL_CNT_W (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_alu_op      (out_alu_op),
      .out_alu_src_imm (out_alu_src_imm),
      .out_is_branch   (out_is_branch),
      .out_is_jal      (out_is_jal),
      .out_is_jalr     (out_is_jalr),
      .out_is_auipc    (out_is_auipc),
      .out_is_lui      (out_is_lui),
      .out_is_load     (out_is_load),
      .out_is_store    (out_is_store),
      .out_is_muldiv   (out_is_muldiv),
      .out_rwe         (out_rwe),
      .out_illegal     (out_illegal),
      .out_rd          (out_rd),
      .out_rs1         (out_rs1),
      .out_rs2         (out_rs2),
      .out_func3       (out_func3),
      .out_imm         (out_imm),
      .stall_count     (stall_count)
   );

`ifdef RV_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  aluOp;
      logic        src, br, jal, jalr, auipc, lui, load, store, muldiv, rwe, illegal;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [31:0] imm;
   } refBundleT;

   int unsigned nChecks = 0;
   int unsigned nPass   = 0;

   logic        mValid;
   refBundleT   mB;
   logic [15:0] mStall;

   task automatic checkVal(input string tag, input logic [95:0] got, input logic [95:0] want);
      nChecks++;
      if (got === want) nPass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, want);
   endtask

   // Reference decode built from field arithmetic on the instruction word.
   function automatic refBundleT refDecode(input logic [31:0] w);
      refBundleT   r;
      logic [6:0]  opc;
      logic [6:0]  f7;
      int          iImm;
      logic        bad;
      r    = '0;
      opc  = w[6:0];
      f7   = w[31:25];
      r.rd = w[11:7];  r.rs1 = w[19:15];  r.rs2 = w[24:20];  r.f3 = w[14:12];
      iImm = $signed(w) >>> 20;
      bad  = 1'b0;
      r.aluOp = {1'b0, r.f3};
      case (opc)
         7'h03: begin r.load = 1'b1; r.aluOp = 4'd0; r.imm = iImm; end
         7'h23: begin
            r.store = 1'b1; r.aluOp = 4'd0;
            r.imm = (iImm & -32) + int'((w >> 7) & 32'd31);
         end
         7'h63: begin
            r.br  = 1'b1;
            r.imm = int'(((w >> 8) & 15) * 2 + ((w >> 25) & 63) * 32 + ((w >> 7) & 1) * 2048)
                    - int'((w >> 31) & 1) * 4096;
         end
         7'h6f: begin
            r.jal = 1'b1;
            r.imm = int'(((w >> 21) & 1023) * 2 + ((w >> 20) & 1) * 2048 + ((w >> 12) & 255) * 4096)
                    - int'(w >> 31) * 1048576;
         end
         7'h67: begin r.jalr = 1'b1; r.imm = iImm; end
         7'h17: begin r.auipc = 1'b1; r.imm = w & 32'hFFFFF000; end
         7'h37: begin r.lui = 1'b1; r.imm = w & 32'hFFFFF000; end
         7'h33: begin
            if (f7 == 7'd0 || f7 == 7'd32) r.aluOp = {f7[5], r.f3};
            else if (MEXT && f7 == 7'd1) r.muldiv = 1'b1;
            else bad = 1'b1;
         end
         7'h13: begin
            r.src = 1'b1; r.imm = iImm;
            if (r.f3 == 3'd1 || r.f3 == 3'd5) r.aluOp = {f7[5], r.f3};
            if (r.f3 == 3'd1 && f7 != 7'd0) bad = 1'b1;
            if (r.f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32) bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         r.illegal = 1'b1; r.src = 1'b0; r.muldiv = 1'b0;
      end
      r.rwe = !r.br && !r.store && !r.illegal && (r.rd != 5'd0);
      return r;
   endfunction

   function automatic refBundleT dutBundle();
      refBundleT r;
      r = {out_alu_op, out_alu_src_imm, out_is_branch, out_is_jal, out_is_jalr,
           out_is_auipc, out_is_lui, out_is_load, out_is_store, out_is_muldiv,
           out_rwe, out_illegal, out_rd, out_rs1, out_rs2, out_func3, out_imm};
      return r;
   endfunction

   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      logic [6:0]  opcs [9];
      int          k;
      opcs = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h17, 7'h37};
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k == 9) return w;
      w[6:0]   = opcs[k];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      if (opcs[k] == 7'h33 || (opcs[k] == 7'h13 && w[13:12] == 2'b01)) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
      end
      return w;
   endfunction

   // One cycle: drive at negedge, check in_ready, advance model at posedge, check at next negedge.
   task automatic step(input logic iv, input logic [31:0] ins, input logic ord, input logic fl);
      refBundleT nb;
      refBundleT got;
      refBundleT want;
      logic      u1, u2, haz, expRdy;
      in_valid = iv;  in_instr = ins;  out_ready = ord;  flush = fl;
      nb  = refDecode(ins);
      u1  = !(nb.lui || nb.auipc || nb.jal);
      u2  = nb.store || nb.br || (ins[6:0] == 7'h33 && !nb.illegal);
      haz = iv && mValid && mB.load && (mB.rd != 5'd0) &&
            ((u1 && nb.rs1 == mB.rd) || (u2 && nb.rs2 == mB.rd));
      expRdy = (!mValid || ord) && !haz && !fl;
      #1 checkVal("in_ready", in_ready, expRdy);
      @(posedge clk);
      if (fl) mValid = 1'b0;
      else if (iv && expRdy) begin mValid = 1'b1; mB = nb; end
      else if (ord) mValid = 1'b0;
      if (haz && ord && !fl && mStall != 16'hFFFF) mStall = mStall + 16'd1;
      @(negedge clk);
      checkVal("out_valid", out_valid, mValid);
      checkVal("stall_count", stall_count, mStall);
      if (mValid) begin
         got  = dutBundle();
         want = mB;
         if (want.illegal) begin
            got.aluOp = '0;  got.imm = '0;  want.aluOp = '0;  want.imm = '0;
         end
         checkVal("bundle", got, want);
      end
   endtask

   initial begin
      reset = 1'b1;  in_valid = 1'b0;  in_instr = '0;  flush = 1'b0;  out_ready = 1'b0;
      mValid = 1'b0;  mB = '0;  mStall = '0;
      repeat (2) @(negedge clk);
      checkVal("rst_valid", out_valid, 1'b0);
      checkVal("rst_stall", stall_count, 16'd0);
      checkVal("rst_bundle", dutBundle(), '0);
      reset = 1'b0;

      step(1'b1, 32'h00500093, 1'b1, 1'b0);
      checkVal("addi_aluop", out_alu_op, 4'b0000);
      checkVal("addi_src", out_alu_src_imm, 1'b1);
      checkVal("addi_imm", out_imm, 32'd5);
      checkVal("addi_rd", out_rd, 5'd1);
      checkVal("addi_rwe", out_rwe, 1'b1);

      step(1'b1, 32'h40335293, 1'b1, 1'b0);
      checkVal("srai_aluop", out_alu_op, 4'b1101);
      checkVal("srai_shamt", out_imm[4:0], 5'd3);

      step(1'b1, 32'h402081B3, 1'b1, 1'b0);
      checkVal("sub_aluop", out_alu_op, 4'b1000);
      checkVal("sub_rwe", out_rwe, 1'b1);
      checkVal("sub_src", out_alu_src_imm, 1'b0);

      step(1'b1, 32'h0000A103, 1'b1, 1'b0);
      step(1'b1, 32'h001101B3, 1'b1, 1'b0);
      checkVal("bubble_valid", out_valid, 1'b0);
      checkVal("bubble_stall", stall_count, 16'd1);
      step(1'b1, 32'h001101B3, 1'b1, 1'b0);
      checkVal("add_issue", out_valid, 1'b1);
      checkVal("add_rd", out_rd, 5'd3);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h00500093, 1'b0, 1'b0);
         checkVal("hold_in_ready", in_ready, 1'b0);
         checkVal("hold_rd", out_rd, 5'd3);
      end
      step(1'b1, 32'h00500093, 1'b1, 1'b1);
      checkVal("flush_valid", out_valid, 1'b0);
      checkVal("flush_stall", stall_count, 16'd1);

      step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
      checkVal("ill_flag", out_illegal, 1'b1);
      checkVal("ill_rwe", out_rwe, 1'b0);
      checkVal("ill_class", {out_is_branch, out_is_jal, out_is_jalr, out_is_auipc,
                             out_is_lui, out_is_load, out_is_store, out_is_muldiv}, 8'd0);

      step(1'b1, 32'h022081B3, 1'b1, 1'b0);
`ifdef RV_MEXT_EN
      checkVal("mul_muldiv", out_is_muldiv, 1'b1);
      checkVal("mul_aluop", out_alu_op, 4'b0000);
      checkVal("mul_rwe", out_rwe, 1'b1);
`else
      checkVal("mul_illegal", out_illegal, 1'b1);
      checkVal("mul_muldiv", out_is_muldiv, 1'b0);
`endif

      step(1'b1, 32'h00500093, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1 checkVal("midrst_valid", out_valid, 1'b0);
      checkVal("midrst_stall", stall_count, 16'd0);
      mValid = 1'b0;  mStall = '0;
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 32'h00500093, 1'b1, 1'b0);
      checkVal("postrst_accept", out_valid, 1'b1);

      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), randInstr(),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
